// File: rtl/arith_pkg.sv
// arith_pkg: op encodings and the pipeline stage record shared by the add/sub pipeline
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the stage record can carry; the top checks WIDTH against it
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] psum;
        logic                 carry;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] b_rem;
    } stage_t;

endpackage

// File: rtl/arith_pipe_addsub_adder_slice.sv
// adder_slice: W-bit combinational ripple adder with carry in, carry out and carry into the MSB
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    logic [W:0] w_c;

    // Ripple the carry bit by bit from the slice carry-in
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        o_sum  = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[W];
    assign o_cmsb = w_c[W-1];

endmodule

// File: rtl/arith_pipe_addsub.sv
// arith_pipe_addsub: STAGES-deep sliced add/sub pipeline with valid/ready; ARITH_ADDSUB_FLAGS_EN enables ovf/zero
module arith_pipe_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SD = (STAGES < 1) ? 1 : STAGES;
    localparam int SW = WIDTH / SD;

    if (STAGES < 1 || (WIDTH % SD) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("arith_pipe_addsub: STAGES must be >= 1, divide WIDTH, and WIDTH <= MAX_WIDTH");
    end

    stage_t r_stg [STAGES];
    logic   w_en;

    // A stalled, full output freezes the whole pipe, bubbles included
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_stg[STAGES-1].valid;
    assign sum       = r_stg[STAGES-1].psum[WIDTH-1:0];
    assign cout      = r_stg[STAGES-1].carry;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits already consumed are dropped from the carried-forward copies
        localparam logic [MAX_WIDTH-1:0] KEEP = ~((MAX_WIDTH'(1) << ((k + 1) * SW)) - MAX_WIDTH'(1));
        logic [MAX_WIDTH-1:0] w_a;
        logic [MAX_WIDTH-1:0] w_b;
        logic [MAX_WIDTH-1:0] w_pi;
        logic [MAX_WIDTH-1:0] w_po;
        logic                 w_ci;
        logic                 w_v;
        logic [SW-1:0]        w_s;
        logic                 w_co;
        logic                 w_cm;
        logic                 w_cm_unused;

        assign w_cm_unused = w_cm;

        if (k == 0) begin : g_in
            // Subtract enters as a + ~b with carry-in 1
            assign w_a  = MAX_WIDTH'(a);
            assign w_b  = MAX_WIDTH'((op == OP_SUB) ? ~b : b);
            assign w_ci = (op == OP_SUB);
            assign w_v  = in_valid;
            assign w_pi = '0;
        end else begin : g_mid
            assign w_a  = r_stg[k-1].a_rem;
            assign w_b  = r_stg[k-1].b_rem;
            assign w_ci = r_stg[k-1].carry;
            assign w_v  = r_stg[k-1].valid;
            assign w_pi = r_stg[k-1].psum;
        end

        adder_slice #(.W(SW)) u_slice (
            .i_a    (w_a[k*SW +: SW]),
            .i_b    (w_b[k*SW +: SW]),
            .i_cin  (w_ci),
            .o_sum  (w_s),
            .o_cout (w_co),
            .o_cmsb (w_cm)
        );

        // Splice this slice's result into the partial sum handed down the pipe
        always_comb begin
            w_po               = w_pi;
            w_po[k*SW +: SW]   = w_s;
        end

        // Stage register advances only with the pipeline enable
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_stg[k] <= '0;
            else if (w_en)
                r_stg[k] <= '{valid: w_v, psum: w_po, carry: w_co, a_rem: w_a & KEEP, b_rem: w_b & KEEP};
        end
    end

`ifdef ARITH_ADDSUB_FLAGS_EN
    logic r_ovf;

    // Signed overflow: carry into MSB differs from carry out, registered with the final slice
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_en)
            r_ovf <= g_stage[STAGES-1].w_cm ^ g_stage[STAGES-1].w_co;
    end

    assign ovf  = r_ovf;
    assign zero = out_valid && (sum == '0);
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_arith_pipe_addsub.sv
// tb_arith_pipe_addsub: scoreboard bench for the add/sub pipeline with directed hand-computed vectors
module tb_arith_pipe_addsub;

    localparam int W = 32;
    localparam int S = 4;
`ifdef ARITH_ADDSUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          t;
        bit          lat;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out = 0;

    logic [31:0] st_a [10] = '{32'h00000001, 32'h80000000, 32'h12345678, 32'h00000010, 32'h0000FFFF,
                               32'h00000000, 32'hF0000000, 32'h40000000, 32'h80000000, 32'hAAAAAAAA};
    logic [31:0] st_b [10] = '{32'h00000002, 32'h80000000, 32'h11111111, 32'h00000001, 32'h00000001,
                               32'h00000001, 32'h10000000, 32'h40000000, 32'h80000000, 32'h55555555};
    logic        st_op[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] st_s [10] = '{32'h00000003, 32'h00000000, 32'h23456789, 32'h0000000F, 32'h00010000,
                               32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    logic        st_c [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        st_o [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        st_z [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    arith_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : push
        exp_t e;
        if (!reset && in_valid && in_ready) begin
            e   = cur;
            e.t = cyc;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: sum=%h cout=%b with no beat pending", sum, cout);
            end else begin
                e = q.pop_front();
                n_out++;
                if (sum !== e.s || cout !== e.c || ovf !== (e.o & FL) || zero !== (e.z & FL)) begin
                    failures++;
                    $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                             e.name, sum, cout, ovf, zero, e.s, e.c, e.o & FL, e.z & FL);
                end
                if (e.lat) begin
                    checks++;
                    if (cyc - e.t != S) begin
                        failures++;
                        $display("FAIL %s_latency: got %0d cycles, expected %0d", e.name, cyc - e.t, S);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input string nm, input logic [31:0] ai, input logic [31:0] bi, input logic opi,
                        input logic [31:0] es, input logic ec, input logic eo, input logic ez, input bit lat);
        int n;
        @(posedge clk);
        #2;
        a        = ai;
        b        = bi;
        op       = opi;
        in_valid = 1'b1;
        cur.s    = es;
        cur.c    = ec;
        cur.o    = eo;
        cur.z    = ez;
        cur.t    = 0;
        cur.lat  = lat;
        cur.name = nm;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: in_ready=%b after %0d cycles, expected 1", nm, in_ready, n);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #2 in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        send("add_ffffffff_1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
        send("add_7fffffff_1", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        send("sub_5_7",        32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        send("sub_7_5",        32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);
        send("sub_min_1",      32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        send("add_slice_carry",32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b1);
        send("sub_0_0",        32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        repeat (8) @(posedge clk);

        base = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send($sformatf("stream_%0d", i), st_a[i], st_b[i], st_op[i], st_s[i], st_c[i], st_o[i], st_z[i], 1'b0);
                idle();
            end
            begin
                n = 0;
                while (n_out < base + 2 && n < 100) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("stream_two_results", 32'(n_out - base), 32'd2);
                @(posedge clk);
                #2 out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_sum_held", sum, st_s[2]);
                    chk("stall_cout_held", 32'(cout), 32'(st_c[2]));
                end
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        chk("stream_all_results", 32'(n_out - base), 32'd10);

        @(posedge clk);
        #2 out_ready = 1'b0;
        send("rst_flight_0", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
        send("rst_flight_1", 32'h00000002, 32'h00000002, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
        send("rst_flight_2", 32'h00000003, 32'h00000003, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("flight_out_valid_before_reset", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", sum, 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        send("post_rst_1_plus_1", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_pipe_addsub.md
ARITH_PIPE_ADDSUB -- requirements
Module: arith_pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline slices; WIDTH % STAGES == 0 and STAGES >= 1 SHALL hold, else elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed two's-complement overflow.
REQ-014 zero  output  1  sum == 0.

Function
REQ-015 Subtract SHALL be computed as a + ~b + 1, with carry-in 1 into slice 0.
REQ-016 Operands SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using the registered carry from stage k-1; lower result slices and not-yet-used operand slices SHALL be carried forward in delay registers.
REQ-017 Beat transfer SHALL occur on a cycle with in_valid && in_ready; result transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-018 Pipeline enable SHALL be en = !out_valid || out_ready; all stage registers, including valid bits, SHALL advance only when en is 1.
REQ-019 in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-020 Latency: a beat accepted at edge t SHALL present out_valid at edge t+STAGES when no stall occurs; each stall cycle adds one cycle.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held 1, including simultaneous accept and drain in the same cycle.
REQ-022 Bubbles SHALL be propagated, not compressed; results SHALL leave in acceptance order with no loss or duplication.
REQ-023 sum, cout, ovf and zero SHALL be held stable while out_valid && !out_ready.
REQ-024 ovf SHALL be carry into MSB XOR carry out of MSB; zero SHALL be computed on the final registered sum.
REQ-025 With STAGES = 1, the block SHALL be a single registered stage with latency 1.

Reset
REQ-026 Asserting reset SHALL immediately clear all valid bits; out_valid SHALL be 0 and sum, cout, ovf and zero SHALL be 0.
REQ-027 Beats in flight when reset asserts SHALL be discarded; the first beat after deassertion SHALL be accepted normally (in_ready = 1).

Configuration
REQ-028 Macro ARITH_ADDSUB_FLAGS_EN defined: ovf and zero SHALL be computed per REQ-024.
REQ-029 Macro undefined: ovf and zero SHALL be constant 0, and their logic and registers SHALL be absent; sum and cout are unaffected.

Structure
REQ-030 Package arith_pkg SHALL hold the op encoding constants (OP_ADD = 0, OP_SUB = 1) and a stage record typedef (valid, partial sum, carry, remaining operand slices).
REQ-031 One sub-module, adder_slice, SHALL implement a combinational parametrised ripple adder of WIDTH/STAGES bits with carry in and carry out, plus the carry into its MSB; it SHALL be instantiated once per stage.

Verification (WIDTH = 32, STAGES = 4, flags enabled unless stated)
REQ-032 add 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, cout 1, zero 1, ovf 0, out_valid exactly 4 cycles after accept.
REQ-033 add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, ovf 1, zero 0.
REQ-034 sub 5 - 7 -> sum 0xFFFFFFFE, cout 0, ovf 0; sub 7 - 5 -> sum 0x00000002, cout 1.
REQ-035 stream 10 random beats back to back, drop out_ready after 2 results for 5 cycles -> in_ready 0 during the stall, outputs held, all 10 results in order and matching the model.
REQ-036 assert reset with 3 beats in flight -> out_valid 0 immediately, no stale result after release; next beat 1 + 1 -> sum 2 after 4 cycles.
REQ-037 ARITH_ADDSUB_FLAGS_EN undefined, repeat REQ-033 -> sum 0x80000000, ovf 0, zero 0.
